regfile_wb_scheduler: RTL and testbench

Schedules the single write port of the 32x64 register file between two writeback sources: ALU results and load data.
- Tracks outstanding destination registers in a scoreboard and produces a decode stall for RAW/WAW hazards.
- The register file reads only in cycles where write_en is low, so the block limits consecutive writes to guarantee read slots.
- Sits between the ALU/load writeback stages and the register file, and feeds stall back to decode.

---
 rtl/regfile_sched_pkg.sv | 16 +
 rtl/regfile_scoreboard.sv | 70 +++++++
 rtl/regfile_wb_scheduler.sv | 154 +++++++++++++++
 tb/tb_regfile_wb_scheduler.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_sched_pkg.sv
// Shared types and constants for the register-file writeback scheduler.
//   reg_addr_t : 5-bit register index (x0..x31)
//   req_id_t   : identifies a writeback requester (ALU or load)
//   NUM_REGS   : number of architectural registers tracked by the scoreboard
package regfile_sched_pkg;

    localparam int NUM_REGS = 32;

    typedef logic [4:0] reg_addr_t;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_LD  = 1'b1
    } req_id_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-register scoreboard feeding the decode stall.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   issue_valid/rd      : decode issuing an instruction that writes issue_rd
//   chk_a / chk_b       : source registers of the instruction in decode
//   clr_en / clr_addr   : register-file write happening this cycle (clears busy)
//   stall               : decode must hold (RAW on a source, WAW on the dest)
//   busy_vec            : registered busy bits, bit 0 always 0
module regfile_scoreboard
    import regfile_sched_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                issue_valid,
    input  reg_addr_t           issue_rd,
    input  reg_addr_t           chk_a,
    input  reg_addr_t           chk_b,
    input  logic                clr_en,
    input  reg_addr_t           clr_addr,
    output logic                stall,
    output logic [NUM_REGS-1:0] busy_vec
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;
    logic                stall_c;

    // Hazard detection from registered busy state; forced low while in reset.
    always_comb begin
        stall_c = 1'b0;
        if (reset) begin
            stall_c = 1'b0;
        end else begin
            stall_c = busy_q[chk_a] | busy_q[chk_b] | (issue_valid & busy_q[issue_rd]);
        end
    end

    // Next busy state: clear first, then set, so a same-edge set wins.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (clr_en) begin
            clr_mask[clr_addr] = 1'b1;
        end else begin
            clr_mask = '0;
        end
        if (issue_valid && !stall_c && (issue_rd != 5'd0)) begin
            set_mask[issue_rd] = 1'b1;
        end else begin
            set_mask = '0;
        end
        busy_d    = (busy_q & ~clr_mask) | set_mask;
        busy_d[0] = 1'b0;
    end

    // Busy-vector register.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign stall    = stall_c;
    assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Arbitrates the single register-file write port between ALU and load
// writeback, enforces a read slot after at most MAX_WR_BURST consecutive
// writes, and tracks outstanding destinations for the decode stall.
// Ports:
//   clk, reset                         : clock, synchronous active-high reset
//   alu_valid/ready/addr/data          : ALU writeback handshake
//   ld_valid/ready/addr/data           : load writeback handshake
//   issue_valid, issue_rd              : decode issue of a register writer
//   chk_addrA, chk_addrB               : decode source registers
//   stall                              : decode hold
//   rf_write_en/addressC/writeBack     : registered register-file write port
//   rf_read_slot                       : register file reads this cycle
//   busy_vec                           : scoreboard state
module regfile_wb_scheduler
    import regfile_sched_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int MAX_WR_BURST   = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      alu_valid,
    output logic                      alu_ready,
    input  logic [4:0]                alu_addr,
    input  logic [BUS_DATA_WIDTH-1:0] alu_data,
    input  logic                      ld_valid,
    output logic                      ld_ready,
    input  logic [4:0]                ld_addr,
    input  logic [BUS_DATA_WIDTH-1:0] ld_data,
    input  logic                      issue_valid,
    input  logic [4:0]                issue_rd,
    input  logic [4:0]                chk_addrA,
    input  logic [4:0]                chk_addrB,
    output logic                      stall,
    output logic                      rf_write_en,
    output logic [4:0]                rf_addressC,
    output logic [BUS_DATA_WIDTH-1:0] rf_writeBack,
    output logic                      rf_read_slot,
    output logic [31:0]               busy_vec
);

    localparam logic [2:0] MAX_RUN = 3'(MAX_WR_BURST);

    req_id_t                   last_grant_q, last_grant_d;
    logic [2:0]                wr_run_q, wr_run_d;
    logic                      we_q, we_d;
    reg_addr_t                 addr_q, addr_d;
    logic [BUS_DATA_WIDTH-1:0] data_q, data_d;

    logic                      alu_gnt;
    logic                      ld_gnt;
    logic                      xfer;
    reg_addr_t                 xfer_addr;
    logic [BUS_DATA_WIDTH-1:0] xfer_data;
    logic                      wr_go;

    // Round-robin grant; a full burst forces one idle cycle to give the RF a read slot.
    always_comb begin
        alu_gnt = 1'b0;
        ld_gnt  = 1'b0;
        if (reset || (wr_run_q == MAX_RUN)) begin
            alu_gnt = 1'b0;
            ld_gnt  = 1'b0;
        end else if (alu_valid && ld_valid) begin
            if (last_grant_q == REQ_LD) begin
                alu_gnt = 1'b1;
            end else begin
                ld_gnt = 1'b1;
            end
        end else if (alu_valid) begin
            alu_gnt = 1'b1;
        end else if (ld_valid) begin
            ld_gnt = 1'b1;
        end else begin
            alu_gnt = 1'b0;
            ld_gnt  = 1'b0;
        end
    end

    // Select the granted request and compute next-state for pointer, run counter and write port.
    always_comb begin
        xfer      = (alu_valid & alu_gnt) | (ld_valid & ld_gnt);
        xfer_addr = 5'd0;
        xfer_data = '0;
        if (alu_gnt) begin
            xfer_addr = alu_addr;
            xfer_data = alu_data;
        end else begin
            xfer_addr = ld_addr;
            xfer_data = ld_data;
        end
        // A write to x0 is accepted but never reaches the RF, so it does not count toward the burst.
        wr_go = xfer & (xfer_addr != 5'd0);

        last_grant_d = last_grant_q;
        if (alu_gnt) begin
            last_grant_d = REQ_ALU;
        end else if (ld_gnt) begin
            last_grant_d = REQ_LD;
        end else begin
            last_grant_d = last_grant_q;
        end

        wr_run_d = 3'd0;
        we_d     = wr_go;
        addr_d   = addr_q;
        data_d   = data_q;
        if (wr_go) begin
            wr_run_d = wr_run_q + 3'd1;
            addr_d   = xfer_addr;
            data_d   = xfer_data;
        end else begin
            wr_run_d = 3'd0;
        end
    end

    // Arbitration state and registered register-file write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= REQ_LD;
            wr_run_q     <= 3'd0;
            we_q         <= 1'b0;
            addr_q       <= 5'd0;
            data_q       <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            wr_run_q     <= wr_run_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
        end
    end

    regfile_scoreboard u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .chk_a       (chk_addrA),
        .chk_b       (chk_addrB),
        .clr_en      (we_q),
        .clr_addr    (addr_q),
        .stall       (stall),
        .busy_vec    (busy_vec)
    );

    assign alu_ready    = alu_gnt;
    assign ld_ready     = ld_gnt;
    assign rf_write_en  = we_q;
    assign rf_addressC  = addr_q;
    assign rf_writeBack = data_q;
    assign rf_read_slot = ~we_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
module tb_regfile_wb_scheduler;

    localparam int W    = 64;
    localparam int MAXB = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         alu_valid, alu_ready, ld_valid, ld_ready;
    logic [4:0]   alu_addr, ld_addr, issue_rd, chk_addrA, chk_addrB, rf_addressC;
    logic [W-1:0] alu_data, ld_data, rf_writeBack;
    logic         issue_valid, stall, rf_write_en, rf_read_slot;
    logic [31:0]  busy_vec;

    int total = 0;
    int bad   = 0;

    // reference model state
    bit           m_busy [32];
    int           m_last;      // 0 = ALU granted last, 1 = load granted last
    int           m_run;       // consecutive real writes so far
    bit           m_we;
    logic [4:0]   m_addr;
    logic [W-1:0] m_data;
    bit           p_ar, p_lr, p_st;

    always #5 clk = ~clk;

    regfile_wb_scheduler #(.BUS_DATA_WIDTH(W), .MAX_WR_BURST(MAXB)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .chk_addrA(chk_addrA), .chk_addrB(chk_addrB), .stall(stall),
        .rf_write_en(rf_write_en), .rf_addressC(rf_addressC), .rf_writeBack(rf_writeBack),
        .rf_read_slot(rf_read_slot), .busy_vec(busy_vec)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] busy_word();
        logic [31:0] v = 32'd0;
        for (int i = 0; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        m_last = 1; m_run = 0; m_we = 1'b0; m_addr = 5'd0; m_data = '0;
    endtask

    // expected handshake and stall for the current inputs
    task automatic predict();
        p_ar = 1'b0; p_lr = 1'b0;
        if (!reset && m_run < MAXB) begin
            if (alu_valid && ld_valid) begin
                if (m_last == 1) p_ar = 1'b1; else p_lr = 1'b1;
            end else if (alu_valid) p_ar = 1'b1;
            else if (ld_valid) p_lr = 1'b1;
        end
        p_st = !reset && (m_busy[chk_addrA] || m_busy[chk_addrB] || (issue_valid && m_busy[issue_rd]));
    endtask

    // one clock: compare all outputs mid-cycle, advance the model, leave time at posedge+1
    task automatic step();
        logic [4:0]   a;
        logic [W-1:0] d;
        @(negedge clk);
        predict();
        chk("alu_ready", alu_ready, p_ar);
        chk("ld_ready", ld_ready, p_lr);
        chk("stall", stall, p_st);
        chk("rf_write_en", rf_write_en, m_we);
        chk("rf_read_slot", rf_read_slot, !m_we);
        chk("rf_addressC", rf_addressC, m_addr);
        chk("rf_writeBack", rf_writeBack, m_data);
        chk("busy_vec", busy_vec, busy_word());
        if (reset) begin
            model_reset();
        end else begin
            if (m_we) m_busy[m_addr] = 1'b0;
            if (issue_valid && !p_st && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
            if (p_ar || p_lr) begin
                a = p_ar ? alu_addr : ld_addr;
                d = p_ar ? alu_data : ld_data;
                m_last = p_ar ? 0 : 1;
                if (a != 5'd0) begin
                    m_we = 1'b1; m_addr = a; m_data = d; m_run++;
                end else begin
                    m_we = 1'b0; m_run = 0;
                end
            end else begin
                m_we = 1'b0; m_run = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_g [6] = '{1, 2, 0, 1, 2, 0};
        int exp_we [7] = '{0, 1, 1, 0, 1, 1, 0};
        int g;

        reset = 1'b1;
        alu_valid = 1'b0; alu_addr = 5'd0; alu_data = '0;
        ld_valid = 1'b0; ld_addr = 5'd0; ld_data = '0;
        issue_valid = 1'b0; issue_rd = 5'd0; chk_addrA = 5'd0; chk_addrB = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        step();
        reset = 1'b0;
        chk("reset_we", rf_write_en, 64'd0);
        chk("reset_slot", rf_read_slot, 64'd1);
        chk("reset_busy", busy_vec, 64'd0);

        // contention, both requesters continuously valid
        alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 64'h11;
        ld_valid = 1'b1; ld_addr = 5'd2; ld_data = 64'h22;
        for (int i = 0; i < 6; i++) begin
            #1;
            g = alu_ready ? 1 : (ld_ready ? 2 : 0);
            chk($sformatf("cont_grant%0d", i), g, exp_g[i]);
            chk($sformatf("cont_we%0d", i), rf_write_en, exp_we[i]);
            step();
        end
        chk("cont_we6", rf_write_en, exp_we[6]);
        alu_valid = 1'b0; ld_valid = 1'b0;
        step();

        // single ALU write
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 64'hDEAD;
        #1 chk("single_ready", alu_ready, 64'd1);
        step();
        alu_valid = 1'b0;
        chk("single_we", rf_write_en, 64'd1);
        chk("single_addr", rf_addressC, 64'd5);
        chk("single_data", rf_writeBack, 64'hDEAD);
        chk("single_slot", rf_read_slot, 64'd0);
        step();

        // RAW on x7 cleared by a load writeback
        issue_valid = 1'b1; issue_rd = 5'd7;
        #1 chk("raw_issue_stall", stall, 64'd0);
        step();
        issue_valid = 1'b0; chk_addrA = 5'd7;
        #1 chk("raw_stall_c2", stall, 64'd1);
        step(); step();
        ld_valid = 1'b1; ld_addr = 5'd7; ld_data = 64'h77;
        #1 chk("raw_ld_ready", ld_ready, 64'd1);
        step();
        ld_valid = 1'b0;
        #1 chk("raw_stall_wr", stall, 64'd1);
        chk("raw_we", rf_write_en, 64'd1);
        step();
        chk("raw_stall_clr", stall, 64'd0);
        chk_addrA = 5'd0;

        // set wins over a same-edge clear of x3
        alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 64'h33;
        step();
        alu_valid = 1'b0; issue_valid = 1'b1; issue_rd = 5'd3;
        #1 chk("setwin_nostall", stall, 64'd0);
        step();
        issue_valid = 1'b0;
        chk("setwin_busy3", busy_vec[3], 64'd1);
        alu_valid = 1'b1;
        step();
        alu_valid = 1'b0;
        step();
        chk("setwin_cleared", busy_vec, 64'd0);

        // x0 handling
        issue_valid = 1'b1; issue_rd = 5'd0;
        step();
        issue_valid = 1'b0;
        chk("x0_busy", busy_vec, 64'd0);
        alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 64'hBAD;
        #1 chk("x0_ready", alu_ready, 64'd1);
        step();
        alu_valid = 1'b0;
        chk("x0_we", rf_write_en, 64'd0);
        step();

        // reset in the middle of traffic
        issue_valid = 1'b1; issue_rd = 5'd4; step();
        issue_rd = 5'd7; step();
        issue_valid = 1'b0;
        chk("mid_busy", busy_vec, 64'h90);
        alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 64'h99;
        step();
        alu_addr = 5'd10; alu_data = 64'hAA; reset = 1'b1; chk_addrA = 5'd4;
        #1 chk("mid_alu_ready", alu_ready, 64'd0);
        chk("mid_ld_ready", ld_ready, 64'd0);
        step();
        reset = 1'b0;
        chk("mid_busy0", busy_vec, 64'd0);
        chk("mid_we0", rf_write_en, 64'd0);
        #1 chk("mid_stall0", stall, 64'd0);
        chk("mid_regrant", alu_ready, 64'd1);
        step();
        alu_valid = 1'b0; chk_addrA = 5'd0;
        step();

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            if (!alu_valid) begin
                alu_valid = 1'($urandom_range(0, 1));
                alu_addr = 5'($urandom_range(0, 7));
                alu_data = {$urandom, $urandom};
            end
            if (!ld_valid) begin
                ld_valid = 1'($urandom_range(0, 1));
                ld_addr = 5'($urandom_range(0, 7));
                ld_data = {$urandom, $urandom};
            end
            issue_valid = 1'($urandom_range(0, 1));
            issue_rd = 5'($urandom_range(0, 7));
            chk_addrA = 5'($urandom_range(0, 7));
            chk_addrB = 5'($urandom_range(0, 7));
            reset = ($urandom_range(0, 59) == 0);
            step();
            if (p_ar) alu_valid = 1'b0;
            if (p_lr) ld_valid = 1'b0;
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
